add_share_arbiter: RTL and testbench

//  Shares one registered WIDTH-bit adder (o = a + b, WIDTH+1-bit result) among NREQ requesters.

---
 rtl/add_share_arb_pkg.sv | 19 +
 rtl/add_share_arbiter_rr_pick.sv | 28 ++
 rtl/add_share_arbiter.sv | 154 +++++++++++++++
 tb/tb_add_share_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_share_arb_pkg.sv
// Shared types for add_share_arbiter: FSM state encoding and the id-width helper.
package add_share_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      CALC  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Width of an index into n items; a single requester still gets one bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/add_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping mod NREQ.
module add_share_arbiter_rr_pick
   import add_share_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int ID_W = clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] ptr,
   output logic [ID_W-1:0] gnt_idx,
   output logic            any
);

   // Walk offsets from farthest to nearest so the nearest valid index wins.
   always_comb begin
      gnt_idx = '0;
      any     = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         int idx;
         idx = (int'(ptr) + i) % NREQ;
         if (req[idx]) begin
            gnt_idx = ID_W'(idx);
            any     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/add_share_arbiter.sv
// One registered adder shared by NREQ requesters with round-robin grant and one op in flight.
// Optional ADD_SHARE_ARB_STATS_EN adds saturating op_count and busy_cycles outputs.
module add_share_arbiter
   import add_share_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   localparam int ID_W = clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output state_t                dbg_state,
   output logic [ID_W-1:0]       dbg_rr_ptr,
   output logic [WIDTH:0]        rsp_sum
`ifdef ADD_SHARE_ARB_STATS_EN
   ,
   output logic [15:0]           op_count,
   output logic [15:0]           busy_cycles
`endif
);

   state_t            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   win_q, win_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
   logic [WIDTH:0]    sum_q, sum_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]   pick_idx;
   logic              pick_any;
   logic              rsp_fire;

   add_share_arbiter_rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
      .req     (req_valid),
      .ptr     (rr_ptr_q),
      .gnt_idx (pick_idx),
      .any     (pick_any)
   );

   assign rsp_fire = (state_q == RESP) && rsp_ready;

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      win_d       = win_q;
      id_d        = id_q;
      a_d         = a_q;
      b_d         = b_q;
      sum_d       = sum_q;
      rsp_valid_d = rsp_valid_q;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               win_d   = pick_idx;
               state_d = GRANT;
            end
         end
         GRANT: begin
            // A winner that dropped valid forfeits this turn; the pointer stays put.
            if (req_valid[win_q]) begin
               a_d     = req_a[int'(win_q)*WIDTH +: WIDTH];
               b_d     = req_b[int'(win_q)*WIDTH +: WIDTH];
               id_d    = win_q;
               state_d = CALC;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            sum_d       = {1'b0, a_q} + {1'b0, b_q};
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rr_ptr_d    = (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         win_q       <= '0;
         id_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         win_q       <= win_d;
         id_q        <= id_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   always_comb begin
      req_ready = '0;
      if (state_q == GRANT) req_ready[win_q] = 1'b1;
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = id_q;
   assign rsp_sum    = sum_q;
   assign dbg_state  = state_q;
   assign dbg_rr_ptr = rr_ptr_q;

`ifdef ADD_SHARE_ARB_STATS_EN
   logic [15:0] op_count_q, op_count_d;
   logic [15:0] busy_cycles_q, busy_cycles_d;

   always_comb begin
      op_count_d    = op_count_q;
      busy_cycles_d = busy_cycles_q;
      if (rsp_fire && (op_count_q != 16'hFFFF)) op_count_d = op_count_q + 16'd1;
      if ((state_q != IDLE) && (busy_cycles_q != 16'hFFFF)) busy_cycles_d = busy_cycles_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         op_count_q    <= '0;
         busy_cycles_q <= '0;
      end else begin
         op_count_q    <= op_count_d;
         busy_cycles_q <= busy_cycles_d;
      end
   end

   assign op_count    = op_count_q;
   assign busy_cycles = busy_cycles_q;
`else
   // Without stats the response handshake strobe has no consumer.
   logic unused_rsp_fire;
   assign unused_rsp_fire = rsp_fire;
`endif

endmodule

// File: tb/tb_add_share_arbiter.sv
// Self-checking bench for add_share_arbiter: scenario tasks plus a response scoreboard.
module tb_add_share_arbiter;
   import add_share_arb_pkg::*;

   localparam int NREQ  = 4;
   localparam int W     = 8;
   localparam int ID_W  = 2;
   localparam int EXP_W = ID_W + W + 1;

   logic                 clk;
   logic                 clear;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*W-1:0]    req_a;
   logic [NREQ*W-1:0]    req_b;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [ID_W-1:0]      rsp_id;
   logic [W:0]           rsp_sum;
   state_t               dbg_state;
   logic [ID_W-1:0]      dbg_rr_ptr;
`ifdef ADD_SHARE_ARB_STATS_EN
   logic [15:0]          op_count;
   logic [15:0]          busy_cycles;
`endif

   logic [EXP_W-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   add_share_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
      .clk        (clk),
      .clear      (clear),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .dbg_state  (dbg_state),
      .dbg_rr_ptr (dbg_rr_ptr),
      .rsp_sum    (rsp_sum)
`ifdef ADD_SHARE_ARB_STATS_EN
      ,
      .op_count   (op_count),
      .busy_cycles(busy_cycles)
`endif
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Scoreboard: compare every response handshake against the next expected entry.
   always @(negedge clk) begin
      if (!clear && rsp_valid && rsp_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_unexpected got id=%0d sum=%0d want=no response", rsp_id, rsp_sum);
         end else begin
            logic [EXP_W-1:0] e;
            e = exp_q.pop_front();
            if ({rsp_id, rsp_sum} !== e)
               $display("FAIL scoreboard_rsp got id=%0d sum=%0d want id=%0d sum=%0d",
                        rsp_id, rsp_sum, e[EXP_W-1 -: ID_W], e[W:0]);
            else
               n_pass++;
         end
      end
   end

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      tick();
      clear = 1'b0;
   endtask

   task automatic set_ops(input int idx, input int a, input int b);
      req_a[idx*W +: W] = W'(a);
      req_b[idx*W +: W] = W'(b);
   endtask

   task automatic push_exp(input int idx, input int a, input int b);
      logic [EXP_W-1:0] e;
      e = {ID_W'(idx), 9'(a + b)};
      exp_q.push_back(e);
   endtask

   // Raise one request, hold it through the accept edge, then wait for the response handshake.
   task automatic run_single(input int idx, input int a, input int b,
                             output logic [NREQ-1:0] gnt, output int lat, output bit ok);
      ok  = 1'b0;
      lat = -1;
      set_ops(idx, a, b);
      req_valid[idx] = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 20 && req_ready == '0; i++) tick();
      gnt = req_ready;
      if (gnt == '0) begin
         req_valid[idx] = 1'b0;
         return;
      end
      tick();
      req_valid[idx] = 1'b0;
      lat = 1;
      for (int i = 0; i < 20 && !rsp_valid; i++) begin
         tick();
         lat++;
      end
      if (!rsp_valid) return;
      tick();
      ok = 1'b1;
   endtask

   // Scenarios
   task automatic test_reset();
      do_clear();
      n_checks++;
      if (req_ready !== 4'b0000) $display("FAIL reset_req_ready got=%b want=0000", req_ready);
      else n_pass++;
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_sum} !== '0)
         $display("FAIL reset_rsp got valid=%b id=%0d sum=%0d want all 0", rsp_valid, rsp_id, rsp_sum);
      else n_pass++;
      n_checks++;
      if (dbg_state !== IDLE || dbg_rr_ptr !== 2'd0)
         $display("FAIL reset_state got state=%0d ptr=%0d want state=0 ptr=0", dbg_state, dbg_rr_ptr);
      else n_pass++;
   endtask

   task automatic test_single();
      logic [NREQ-1:0] gnt;
      int lat;
      bit ok;
      push_exp(0, 3, 4);
      run_single(0, 3, 4, gnt, lat, ok);
      n_checks++;
      if (gnt !== 4'b0001) $display("FAIL single_grant got=%b want=0001", gnt);
      else n_pass++;
      n_checks++;
      if (lat !== 2) $display("FAIL single_latency got=%0d want=2", lat);
      else n_pass++;
      n_checks++;
      if (!ok || dbg_state !== IDLE) $display("FAIL single_done got ok=%0d state=%0d want ok=1 state=0", ok, dbg_state);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      int grants;
      int cyc;
      int last_cyc;
      do_clear();
      for (int i = 0; i < NREQ; i++) set_ops(i, $urandom_range(0, 255), $urandom_range(0, 255));
      rsp_ready = 1'b1;
      req_valid = 4'b1111;
      grants = 0;
      cyc = 0;
      last_cyc = 0;
      for (int i = 0; i < 60 && grants < 5; i++) begin
         tick();
         cyc++;
         if (req_ready != '0) begin
            int idx;
            idx = 0;
            for (int j = 0; j < NREQ; j++) if (req_ready[j]) idx = j;
            n_checks++;
            if (!$onehot(req_ready)) $display("FAIL rr_onehot got=%b want one-hot", req_ready);
            else n_pass++;
            n_checks++;
            if (idx !== grants % NREQ) $display("FAIL rr_order got=%0d want=%0d", idx, grants % NREQ);
            else n_pass++;
            if (grants > 0) begin
               n_checks++;
               if (cyc - last_cyc !== 4) $display("FAIL rr_period got=%0d want=4", cyc - last_cyc);
               else n_pass++;
            end
            push_exp(idx, int'(req_a[idx*W +: W]), int'(req_b[idx*W +: W]));
            last_cyc = cyc;
            grants++;
            tick();
            cyc++;
            n_checks++;
            if (req_ready !== 4'b0000) $display("FAIL rr_single_cycle got=%b want=0000", req_ready);
            else n_pass++;
            set_ops(idx, $urandom_range(0, 255), $urandom_range(0, 255));
            if (grants == 5) req_valid = '0;
         end
      end
      req_valid = '0;
      n_checks++;
      if (grants !== 5) $display("FAIL rr_grant_count got=%0d want=5", grants);
      else n_pass++;
      for (int i = 0; i < 10 && (dbg_state != IDLE || rsp_valid); i++) tick();
      n_checks++;
      if (exp_q.size() !== 0) $display("FAIL rr_drain got=%0d pending want=0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_max_operands();
      logic [NREQ-1:0] gnt;
      int lat;
      bit ok;
      push_exp(2, 255, 255);
      run_single(2, 255, 255, gnt, lat, ok);
      n_checks++;
      if (!ok || gnt !== 4'b0100) $display("FAIL max_op_grant got ok=%0d gnt=%b want ok=1 gnt=0100", ok, gnt);
      else n_pass++;
      push_exp(3, 0, 0);
      run_single(3, 0, 0, gnt, lat, ok);
      n_checks++;
      if (!ok || gnt !== 4'b1000) $display("FAIL zero_op_grant got ok=%0d gnt=%b want ok=1 gnt=1000", ok, gnt);
      else n_pass++;
   endtask

   task automatic test_back_pressure();
      req_valid = '0;
      rsp_ready = 1'b0;
      set_ops(1, 100, 27);
      req_valid[1] = 1'b1;
      push_exp(1, 100, 27);
      for (int i = 0; i < 20 && req_ready == '0; i++) tick();
      n_checks++;
      if (req_ready !== 4'b0010) $display("FAIL bp_grant got=%b want=0010", req_ready);
      else n_pass++;
      tick();
      req_valid[1] = 1'b0;
      set_ops(3, 200, 100);
      req_valid[3] = 1'b1;
      for (int i = 0; i < 10 && !rsp_valid; i++) tick();
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if ({rsp_valid, rsp_id, rsp_sum, req_ready} !== {1'b1, 2'd1, 9'd127, 4'b0000})
            $display("FAIL bp_hold cycle=%0d got valid=%b id=%0d sum=%0d ready=%b want valid=1 id=1 sum=127 ready=0000",
                     i, rsp_valid, rsp_id, rsp_sum, req_ready);
         else n_pass++;
         tick();
      end
      push_exp(3, 200, 100);
      rsp_ready = 1'b1;
      tick();
      n_checks++;
      if (dbg_state !== IDLE) $display("FAIL bp_release got state=%0d want=0", dbg_state);
      else n_pass++;
      for (int i = 0; i < 10 && req_ready == '0; i++) tick();
      n_checks++;
      if (req_ready !== 4'b1000) $display("FAIL bp_next_grant got=%b want=1000", req_ready);
      else n_pass++;
      tick();
      req_valid[3] = 1'b0;
      for (int i = 0; i < 10 && !rsp_valid; i++) tick();
      tick();
   endtask

   task automatic test_forfeit();
      logic [NREQ-1:0] gnt;
      int lat;
      bit ok;
      do_clear();
      set_ops(1, 9, 9);
      req_valid = 4'b0010;
      tick();
      n_checks++;
      if (req_ready !== 4'b0010 || dbg_state !== GRANT)
         $display("FAIL forfeit_grant got ready=%b state=%0d want ready=0010 state=1", req_ready, dbg_state);
      else n_pass++;
      req_valid = '0;
      tick();
      n_checks++;
      if (dbg_state !== IDLE || dbg_rr_ptr !== 2'd0 || rsp_valid !== 1'b0)
         $display("FAIL forfeit_idle got state=%0d ptr=%0d valid=%b want state=0 ptr=0 valid=0",
                  dbg_state, dbg_rr_ptr, rsp_valid);
      else n_pass++;
      tick();
      push_exp(2, 17, 25);
      run_single(2, 17, 25, gnt, lat, ok);
      n_checks++;
      if (!ok || gnt !== 4'b0100) $display("FAIL forfeit_next got ok=%0d gnt=%b want ok=1 gnt=0100", ok, gnt);
      else n_pass++;
      n_checks++;
      if (dbg_rr_ptr !== 2'd3) $display("FAIL forfeit_ptr got=%0d want=3", dbg_rr_ptr);
      else n_pass++;
   endtask

   task automatic test_clear_mid_op();
      logic [NREQ-1:0] gnt;
      int lat;
      bit ok;
      bit seen;
      push_exp(1, 10, 20);
      run_single(1, 10, 20, gnt, lat, ok);
      n_checks++;
      if (!ok || dbg_rr_ptr !== 2'd2) $display("FAIL clr_setup got ok=%0d ptr=%0d want ok=1 ptr=2", ok, dbg_rr_ptr);
      else n_pass++;
      set_ops(2, 50, 60);
      req_valid[2] = 1'b1;
      for (int i = 0; i < 10 && req_ready == '0; i++) tick();
      tick();
      req_valid[2] = 1'b0;
      n_checks++;
      if (dbg_state !== CALC) $display("FAIL clr_in_calc got state=%0d want=2", dbg_state);
      else n_pass++;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b0) $display("FAIL clr_rsp_valid got=%b want=0", rsp_valid);
      else n_pass++;
      n_checks++;
      if (dbg_rr_ptr !== 2'd0 || dbg_state !== IDLE)
         $display("FAIL clr_state got ptr=%0d state=%0d want ptr=0 state=0", dbg_rr_ptr, dbg_state);
      else n_pass++;
`ifdef ADD_SHARE_ARB_STATS_EN
      n_checks++;
      if (op_count !== 16'd0) $display("FAIL clr_op_count got=%0d want=0", op_count);
      else n_pass++;
`endif
      rsp_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (rsp_valid) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0) $display("FAIL clr_no_rsp got response want none");
      else n_pass++;
   endtask

   initial begin
      clear     = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_max_operands();
      test_back_pressure();
      test_forfeit();
      test_clear_mid_op();
      n_checks++;
      if (exp_q.size() !== 0) $display("FAIL final_queue got=%0d pending want=0", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
